// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit encodings, field offsets and port identifiers for the mesh router
package noc_pkg;

  localparam int FLIT_W_DEF = 64;
  localparam int COORD_W    = 4;

  // Field positions, counted down from the flit MSB.
  localparam int TYPE_OFS = 1;
  localparam int ROW_OFS  = 2;
  localparam int COL_OFS  = 6;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } route_state_e;

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - synchronous flit FIFO with occupancy count
module noc_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           front,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign empty   = (count == '0);
  assign front   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_input_port.sv
// rtl/router_input_port.sv - mesh router input buffer with XY route computation and packet tracking
module router_input_port
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = 4,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int MY_ROW = 0,
  parameter int MY_COL = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FLIT_W-1:0]          in_flit,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FLIT_W-1:0]          out_flit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_port,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       pkt_active,
  output logic [1:0]                 err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [COORD_W:0]   ROWS_C   = (COORD_W+1)'(ROWS);
  localparam logic [COORD_W:0]   COLS_C   = (COORD_W+1)'(COLS);
  localparam logic [COORD_W-1:0] MY_ROW_C = COORD_W'(MY_ROW);
  localparam logic [COORD_W-1:0] MY_COL_C = COORD_W'(MY_COL);

  logic [FLIT_W-1:0]  front;
  logic               empty;
  flit_type_e         ftype;
  logic [COORD_W-1:0] drow;
  logic [COORD_W-1:0] dcol;
  logic               is_head;
  logic               range_err;
  logic               forwardable;
  logic               drop;
  logic               fwd;
  port_e              route;
  port_e              port_q;
  route_state_e       state;

  assign in_ready = (occupancy != FULL_CNT);

  noc_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (in_flit),
    .pop       (fwd || drop),
    .front     (front),
    .empty     (empty),
    .count     (occupancy)
  );

  assign ftype     = flit_type_e'(front[FLIT_W-1-TYPE_OFS +: 2]);
  assign drow      = front[FLIT_W-1-ROW_OFS -: COORD_W];
  assign dcol      = front[FLIT_W-1-COL_OFS -: COORD_W];
  assign is_head   = (ftype == FT_HEAD) || (ftype == FT_HEADTAIL);
  assign range_err = ({1'b0, drow} >= ROWS_C) || ({1'b0, dcol} >= COLS_C);

  // Dimension-ordered routing: resolve the column first, then the row.
  always_comb begin
    route = PORT_L;
    if (range_err)            route = PORT_L;
    else if (dcol > MY_COL_C) route = PORT_E;
    else if (dcol < MY_COL_C) route = PORT_W;
    else if (drow > MY_ROW_C) route = PORT_S;
    else if (drow < MY_ROW_C) route = PORT_N;
    else                      route = PORT_L;
  end

  // Heads open a packet only in IDLE; body/tail flits only continue one in ACTIVE.
  assign forwardable = (state == ST_IDLE) ? is_head : !is_head;
  assign out_valid   = !empty && forwardable;
  assign drop        = !empty && !forwardable;
  assign fwd         = out_valid && out_ready;
  assign out_flit    = front;
  assign out_port    = (state == ST_ACTIVE) ? port_q : route;
  assign pkt_active  = (state == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      port_q <= PORT_N;
      err    <= 2'b00;
    end else begin
      if (drop) err[0] <= 1'b1;
      if (fwd) begin
        if (state == ST_IDLE) begin
          if (range_err) err[1] <= 1'b1;
          if (ftype == FT_HEAD) begin
            state  <= ST_ACTIVE;
            port_q <= route;
          end
        end else if (ftype == FT_TAIL) begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_input_port.sv
// tb/tb_router_input_port.sv - directed self-checking bench for router_input_port at mesh position (1,1)
module tb_router_input_port;

  localparam int FW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_port;
  logic [2:0]    occupancy;
  logic          pkt_active;
  logic [1:0]    err;

  int total = 0;
  int bad   = 0;

  router_input_port #(
    .FLIT_W(FW), .DEPTH(4), .ROWS(4), .COLS(4), .MY_ROW(1), .MY_COL(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_port   (out_port),
    .occupancy  (occupancy),
    .pkt_active (pkt_active),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [3:0] r,
                                       input logic [3:0] c, input logic [15:0] tag);
    return {t, r, c, 38'd0, tag};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [FW-1:0] pkt [5];
  logic [FW-1:0] rt_flit [3];
  logic [2:0]    rt_port [3];
  int            got;
  logic          push_now;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_occ", occupancy, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_pkt", pkt_active, 0);
    check("rst_err", err, 0);
    check("rst_iready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // HEADTAIL to (1,3): east, single-flit packet
    in_flit = mk(2'b11, 4'd1, 4'd3, 16'h0A01); in_valid = 1'b1;
    check("ht_same_cycle_ovalid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("ht_ovalid", out_valid, 1);
    check("ht_port", out_port, 1);
    check("ht_flit", out_flit, mk(2'b11, 4'd1, 4'd3, 16'h0A01));
    check("ht_pkt", pkt_active, 0);
    out_ready = 1'b1;
    tick();
    check("ht_pkt_after", pkt_active, 0);
    check("ht_occ_after", occupancy, 0);

    // HEAD (3,1), BODY, BODY, TAIL streamed with out_ready high: south
    pkt[0] = mk(2'b01, 4'd3, 4'd1, 16'h1000);
    pkt[1] = mk(2'b00, 4'd0, 4'd0, 16'h1001);
    pkt[2] = mk(2'b00, 4'd0, 4'd0, 16'h1002);
    pkt[3] = mk(2'b10, 4'd0, 4'd0, 16'h1003);
    in_flit = pkt[0]; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) in_flit = pkt[i+1];
      else in_valid = 1'b0;
      check("s_ovalid", out_valid, 1);
      check("s_flit", out_flit, pkt[i]);
      check("s_port", out_port, 2);
      check("s_pkt", pkt_active, (i == 0) ? 1'b0 : 1'b1);
      tick();
    end
    check("s_pkt_end", pkt_active, 0);
    check("s_occ_end", occupancy, 0);

    // Backpressure: five flits into a four-deep buffer, then release
    out_ready = 1'b0;
    pkt[0] = mk(2'b01, 4'd1, 4'd2, 16'h2000);
    pkt[1] = mk(2'b00, 4'd0, 4'd0, 16'h2001);
    pkt[2] = mk(2'b00, 4'd0, 4'd0, 16'h2002);
    pkt[3] = mk(2'b00, 4'd0, 4'd0, 16'h2003);
    pkt[4] = mk(2'b10, 4'd0, 4'd0, 16'h2004);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_flit = pkt[i];
      check("bp_iready", in_ready, 1);
      tick();
    end
    in_flit = pkt[4];
    check("bp_full_iready", in_ready, 0);
    check("bp_full_occ", occupancy, 4);
    tick();
    check("bp_hold_occ", occupancy, 4);
    check("bp_hold_flit", out_flit, pkt[0]);
    check("bp_hold_port", out_port, 1);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (out_valid) begin
        check("bp_order", out_flit, pkt[got]);
        got++;
      end
      push_now = in_valid && in_ready;
      tick();
      if (push_now) in_valid = 1'b0;
    end
    check("bp_count", got, 5);
    check("bp_occ_end", occupancy, 0);
    check("bp_pkt_end", pkt_active, 0);

    // Orphan BODY in IDLE is dropped
    in_flit = mk(2'b00, 4'd0, 4'd0, 16'h3000); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("drop_ovalid", out_valid, 0);
    check("drop_occ", occupancy, 1);
    tick();
    check("drop_occ_after", occupancy, 0);
    check("drop_err", err, 2'b01);

    // Remaining routes: west, north, local
    rt_flit[0] = mk(2'b11, 4'd1, 4'd0, 16'h4000); rt_port[0] = 3'd3;
    rt_flit[1] = mk(2'b11, 4'd0, 4'd1, 16'h4001); rt_port[1] = 3'd0;
    rt_flit[2] = mk(2'b11, 4'd1, 4'd1, 16'h4002); rt_port[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0; in_flit = rt_flit[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rt_port", out_port, rt_port[i]);
      check("rt_ovalid", out_valid, 1);
      out_ready = 1'b1;
      tick();
    end
    check("rt_err", err, 2'b01);

    // Out-of-range destination goes local and flags err[1]
    in_flit = mk(2'b01, 4'd7, 4'd0, 16'h5000); in_valid = 1'b1;
    tick();
    in_flit = mk(2'b10, 4'd0, 4'd0, 16'h5001);
    check("oor_port", out_port, 4);
    check("oor_ovalid", out_valid, 1);
    tick();
    in_valid = 1'b0;
    check("oor_err", err, 2'b11);
    check("oor_pkt", pkt_active, 1);
    check("oor_tail_port", out_port, 4);
    check("oor_tail_ovalid", out_valid, 1);
    tick();
    check("oor_pkt_end", pkt_active, 0);

    // Reset mid-packet discards buffered flits
    out_ready = 1'b0;
    in_flit = mk(2'b01, 4'd2, 4'd1, 16'h6000); in_valid = 1'b1;
    tick();
    in_flit = mk(2'b00, 4'd0, 4'd0, 16'h6001);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mid_pkt", pkt_active, 1);
    check("mid_occ", occupancy, 1);
    rst_n = 1'b0;
    tick();
    check("mrst_occ", occupancy, 0);
    check("mrst_pkt", pkt_active, 0);
    check("mrst_ovalid", out_valid, 0);
    check("mrst_err", err, 0);
    rst_n = 1'b1;
    in_flit = mk(2'b10, 4'd0, 4'd0, 16'h7000); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_tail_ovalid", out_valid, 0);
    tick();
    check("post_rst_occ", occupancy, 0);
    check("post_rst_err", err, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
